// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word pipeline requests into word-wide data_memory cycles.
// Optional misalignment trapping is enabled by defining LSU_ALIGN_CHECK_EN.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_is_store,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        MERGE_WR,
        WR,
        RESP
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                w_accept;
    logic                w_misaligned;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_lane;
    logic [1:0]          r_size;
    logic                r_signed;
    logic                r_is_store;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_wr_data;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic [7:0]          w_load_byte;
    logic [15:0]         w_load_half;
    logic [DATA_W-1:0]   w_load_data;
    logic [DATA_W-1:0]   w_merged;

    assign w_accept = req_valid && (r_state == IDLE);

`ifdef LSU_ALIGN_CHECK_EN
    logic r_resp_err;

    assign w_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));
    assign resp_err     = r_resp_err;

    // The only path that enters RESP straight from IDLE is a trapped misaligned access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_err <= 1'b0;
        end else if ((w_next_state == RESP) && (r_state != RESP)) begin
            r_resp_err <= (r_state == IDLE);
        end
    end
`else
    assign w_misaligned = 1'b0;
    assign resp_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_misaligned) begin
                        w_next_state = RESP;
                    end else if (req_is_store && req_size[1]) begin
                        w_next_state = WR;
                    end else begin
                        w_next_state = RD;
                    end
                end
            end
            RD:       w_next_state = RD_WAIT;
            RD_WAIT:  w_next_state = r_is_store ? MERGE_WR : RESP;
            MERGE_WR: w_next_state = RESP;
            WR:       w_next_state = RESP;
            RESP:     w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // Write data is gated so the memory bus never shows stale data without a strobe.
    always_comb begin
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = '0;
        case (r_state)
            IDLE:     req_ready = 1'b1;
            RD:       mem_read = 1'b1;
            MERGE_WR: begin
                mem_write      = 1'b1;
                mem_write_data = r_wr_data;
            end
            WR: begin
                mem_write      = 1'b1;
                mem_write_data = r_wr_data;
            end
            RESP:     resp_valid = 1'b1;
            default:  ;
        endcase
    end

    assign mem_address = r_addr;
    assign resp_rdata  = r_resp_rdata;

    always_comb begin
        w_load_byte = mem_read_data[7:0];
        case (r_lane)
            2'd1:    w_load_byte = mem_read_data[15:8];
            2'd2:    w_load_byte = mem_read_data[23:16];
            2'd3:    w_load_byte = mem_read_data[31:24];
            default: w_load_byte = mem_read_data[7:0];
        endcase
        w_load_half = r_lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];

        case (r_size)
            2'b00:   w_load_data = r_signed ? {{24{w_load_byte[7]}}, w_load_byte}
                                            : {24'h000000, w_load_byte};
            2'b01:   w_load_data = r_signed ? {{16{w_load_half[15]}}, w_load_half}
                                            : {16'h0000, w_load_half};
            default: w_load_data = mem_read_data;
        endcase
    end

    // Sub-word store: only the addressed lane of the freshly read word is replaced.
    always_comb begin
        w_merged = mem_read_data;
        case (r_size)
            2'b00: begin
                case (r_lane)
                    2'd0:    w_merged[7:0]   = r_wdata[7:0];
                    2'd1:    w_merged[15:8]  = r_wdata[7:0];
                    2'd2:    w_merged[23:16] = r_wdata[7:0];
                    default: w_merged[31:24] = r_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (r_lane[1]) begin
                    w_merged[31:16] = r_wdata[15:0];
                end else begin
                    w_merged[15:0]  = r_wdata[15:0];
                end
            end
            default: w_merged = r_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_lane       <= 2'b00;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_is_store   <= 1'b0;
            r_wdata      <= '0;
            r_wr_data    <= '0;
            r_resp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr     <= {req_addr[ADDR_W-1:2], 2'b00};
                r_lane     <= req_addr[1:0];
                r_size     <= req_size;
                r_signed   <= req_signed;
                r_is_store <= req_is_store;
                r_wdata    <= req_wdata;
                r_wr_data  <= req_wdata;
            end

            if ((r_state == RD_WAIT) && r_is_store) begin
                r_wr_data <= w_merged;
            end

            if ((r_state == RD_WAIT) && !r_is_store) begin
                r_resp_rdata <= w_load_data;
            end else if ((w_next_state == RESP) && (r_state != RESP)) begin
                r_resp_rdata <= '0;
            end
        end
    end

endmodule
